// File: rtl/code_conv_pkg.sv
// Shared types and constants for the code_conv_pipe converter slice.
package code_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_B2G     = 2'd1,
        MODE_G2B     = 2'd2,
        MODE_BCD2XS3 = 2'd3
    } mode_e;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/code_conv_core.sv
// Combinational W-bit code converter: pass, bin->Gray, Gray->bin, BCD->excess-3.
module code_conv_core
    import code_conv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] data,
    input  mode_e        mode,
    output logic [W-1:0] res,
    output logic         err
);
    localparam int NUM_LANES = W / 4;

    logic [W-1:0]                g2b;
    logic [NUM_LANES-1:0][3:0]   xs3;
    logic [NUM_LANES-1:0]        nib_err;

    // Gray->binary bit i is the XOR of all Gray bits at or above i.
    for (genvar i = 0; i < W; i++) begin : g_g2b
        assign g2b[i] = ^data[W-1:i];
    end

    // Invalid BCD digits pass through untouched so the bad digit stays visible.
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_nib
        logic [3:0] nib;
        assign nib        = data[4*n +: 4];
        assign nib_err[n] = (nib > BCD_MAX);
        assign xs3[n]     = nib_err[n] ? nib : nib + XS3_OFFSET;
    end

    always_comb begin
        res = data;
        err = 1'b0;
        case (mode)
            MODE_PASS:    res = data;
            MODE_B2G:     res = data ^ (data >> 1);
            MODE_G2B:     res = g2b;
            MODE_BCD2XS3: begin
                res = xs3;
                err = |nib_err;
            end
            default:      res = data;
        endcase
    end

endmodule

// File: rtl/code_conv_pipe.sv
// Two-stage valid/ready code converter with delivered-word counter.
// Optional odd-parity output port out_par when CODE_CONV_PARITY_EN is defined.
module code_conv_pipe
    import code_conv_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_err,
`ifdef CODE_CONV_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] out_cnt
);
    logic         s1_valid;
    logic [W-1:0] s1_data;
    mode_e        s1_mode;
    logic         s1_adv, s2_adv;
    logic [W-1:0] conv_data;
    logic         conv_err;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;

    code_conv_core #(.W(W)) u_core (
        .data (s1_data),
        .mode (s1_mode),
        .res  (conv_data),
        .err  (conv_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_mode   <= MODE_PASS;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_cnt   <= '0;
`ifdef CODE_CONV_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_mode <= mode_e'(in_mode);
                end
            end
            // Payload only moves with a valid word so a stalled output stays stable.
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= conv_data;
                    out_err  <= conv_err;
`ifdef CODE_CONV_PARITY_EN
                    out_par  <= ~^conv_data;
`endif
                end
            end
            if (out_valid && out_ready)
                out_cnt <= out_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_code_conv_pipe.sv
// Directed, table-driven bench for code_conv_pipe (W=8, CNT_W=4).
module tb_code_conv_pipe;
    localparam int W     = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] din;
        logic [W-1:0] exp_data;
        logic         exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_err;
    logic [CNT_W-1:0] out_cnt;
`ifdef CODE_CONV_PARITY_EN
    logic             out_par;
`endif

    int tests = 0;
    int fails = 0;

    vec_t vecs[64];
    int   nvec = 0;

    code_conv_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
`ifdef CODE_CONV_PARITY_EN
        .out_par   (out_par),
`endif
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] m, input logic [W-1:0] d,
                       input logic [W-1:0] e, input logic ee);
        vecs[nvec] = '{mode: m, din: d, exp_data: e, exp_err: ee};
        nvec++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    logic [W-1:0] gray_tab[16];
    logic [W-1:0] bp_w[5];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;

        gray_tab = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                     8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};
        for (int i = 0; i < 16; i++) add(2'd1, W'(i), gray_tab[i], 1'b0);
        for (int i = 0; i < 16; i++) add(2'd2, gray_tab[i], W'(i), 1'b0);
        add(2'd2, 8'h07, 8'h05, 1'b0);
        add(2'd2, 8'h08, 8'h0F, 1'b0);
        add(2'd0, 8'hA5, 8'hA5, 1'b0);
        add(2'd3, 8'h09, 8'h3C, 1'b0);
        add(2'd3, 8'h00, 8'h33, 1'b0);
        add(2'd3, 8'h0A, 8'h3A, 1'b1);
        add(2'd3, 8'h47, 8'h7A, 1'b0);
        add(2'd3, 8'h4C, 8'h7C, 1'b1);
        add(2'd1, 8'hFF, 8'h80, 1'b0);
        add(2'd0, 8'h9C, 8'h9C, 1'b0);
        add(2'd3, 8'h99, 8'hCC, 1'b0);
        add(2'd3, 8'hF2, 8'hF5, 1'b1);

        // Reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back stream, mixed modes: output after edge j is vector j-2.
        out_ready = 1'b1;
        for (int i = 0; i <= nvec; i++) begin
            @(negedge clk);
            in_valid = (i < nvec);
            if (i < nvec) begin
                in_data = vecs[i].din;
                in_mode = vecs[i].mode;
            end
            #1;
            if (i < nvec) chk($sformatf("stream_in_ready[%0d]", i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            if (i >= 1) begin
                chk($sformatf("stream_valid[%0d]", i-1), 32'(out_valid), 32'd1);
                chk($sformatf("stream_data[%0d]", i-1), 32'(out_data), 32'(vecs[i-1].exp_data));
                chk($sformatf("stream_err[%0d]", i-1), 32'(out_err), 32'(vecs[i-1].exp_err));
`ifdef CODE_CONV_PARITY_EN
                chk($sformatf("stream_par[%0d]", i-1), 32'(out_par), 32'(~^vecs[i-1].exp_data));
`endif
            end
        end
        @(posedge clk); #1;
        chk("stream_drain_valid", 32'(out_valid), 32'd0);
        chk("stream_cnt", 32'(out_cnt), 32'(nvec % 16));

`ifdef CODE_CONV_PARITY_EN
        // Direct parity cases: 0x07 has three ones, 0x03 has two.
        do_reset();
        in_valid = 1'b1; in_mode = 2'd0; in_data = 8'h07;
        @(negedge clk); in_data = 8'h03;
        @(negedge clk); in_valid = 1'b0;
        chk("par_0x07", 32'(out_par), 32'd0);
        @(negedge clk);
        chk("par_0x03", 32'(out_par), 32'd1);
`endif

        // Backpressure: 5 words, consumer stalled for the first 6 cycles.
        do_reset();
        bp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        begin
            int k = 0, r = 0, gaps = 0;
            logic acc_now;
            for (int c = 0; c < 40 && r < 5; c++) begin
                @(negedge clk);
                out_ready = (c >= 6);
                in_valid  = (k < 5);
                in_mode   = 2'd0;
                in_data   = (k < 5) ? bp_w[k] : 8'h00;
                #1;
                if (c == 5) begin
                    chk("bp_accepts", 32'(k), 32'd2);
                    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                    chk("bp_hold_valid", 32'(out_valid), 32'd1);
                    chk("bp_hold_data", 32'(out_data), 32'(bp_w[0]));
                end
                acc_now = in_valid && in_ready;
                if (out_valid && out_ready) begin
                    chk($sformatf("bp_order[%0d]", r), 32'(out_data), 32'(bp_w[r]));
                    r++;
                end else if (c >= 6) begin
                    gaps++;
                end
                @(posedge clk);
                if (acc_now) k++;
            end
            #1;
            chk("bp_delivered", 32'(r), 32'd5);
            chk("bp_gaps", 32'(gaps), 32'd0);
            chk("bp_cnt", 32'(out_cnt), 32'd5);
        end

        // Reset with two words in flight (one is handshaking on the reset edge).
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        do_reset();
        in_valid = 1'b1; in_mode = 2'd0; in_data = 8'hAA;
        @(negedge clk); in_data = 8'hBB;
        @(negedge clk); in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_cnt", 32'(out_cnt), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_mode = 2'd1; in_data = 8'h05;
        @(negedge clk); in_valid = 1'b0;
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("mid_next_valid", 32'(out_valid), 32'd1);
        chk("mid_next_data", 32'(out_data), 32'h07);
        chk("mid_next_cnt", 32'(out_cnt), 32'd0);

        // Counter wrap: 17 handshakes on a 4-bit counter.
        do_reset();
        in_valid = 1'b1; in_mode = 2'd0;
        for (int i = 0; i < 17; i++) begin
            in_data = W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("wrap_cnt", 32'(out_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
